// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serves the ball, detects misses once per frame,
// keeps score, ramps ball velocity on bounces and declares the winner.
module pong_game_ctrl #(
  parameter int          LEFT_X       = 8,
  parameter int          RIGHT_X      = 1256,
  parameter int          RACK_H       = 64,
  parameter int          BALL_H       = 16,
  parameter int          SERVE_FRAMES = 60,
  parameter int          POINT_FRAMES = 30,
  parameter int          WIN_SCORE    = 5,
  parameter logic [15:0] VEL_INIT     = 16'h0100,
  parameter logic [15:0] VEL_STEP     = 16'h0010,
  parameter logic [15:0] VEL_MAX      = 16'h0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start_strobe,
  input  logic        start_btn,
  input  logic [11:0] ball_x,
  input  logic [11:0] ball_y,
  input  logic [11:0] rack_y_L,
  input  logic [11:0] rack_y_R,
  input  logic        ball_bounce,
  output logic        ball_enable,
  output logic        ball_serve,
  output logic [15:0] velocity,
  output logic [3:0]  score_L,
  output logic [3:0]  score_R,
  output logic        game_over,
  output logic        winner,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]  POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [11:0] LEFT_LIM   = 12'(LEFT_X);
  localparam logic [11:0] RIGHT_LIM  = 12'(RIGHT_X);
  localparam logic [12:0] RACK_H13   = 13'(RACK_H);
  localparam logic [12:0] BALL_H13   = 13'(BALL_H);

  state_t      cur_state, nxt_state;
  logic [7:0]  frame_cnt, cnt_n;
  logic [15:0] vel_n;
  logic [3:0]  score_l_n, score_r_n;
  logic        winner_n, serve_n, enable_n, over_n;

  // Bottom edges are formed one bit wider so a racket near the screen edge
  // cannot wrap around and fake a cover.
  logic [12:0] ball_bot, rack_l_bot, rack_r_bot;
  logic        miss_l, miss_r;
  logic [16:0] vel_sum;
  logic [15:0] vel_bumped;

  assign ball_bot   = {1'b0, ball_y}   + BALL_H13;
  assign rack_l_bot = {1'b0, rack_y_L} + RACK_H13;
  assign rack_r_bot = {1'b0, rack_y_R} + RACK_H13;

  assign miss_l = (ball_x <= LEFT_LIM) &&
                  ((ball_bot <= {1'b0, rack_y_L}) || ({1'b0, ball_y} >= rack_l_bot));
  assign miss_r = (ball_x >= RIGHT_LIM) &&
                  ((ball_bot <= {1'b0, rack_y_R}) || ({1'b0, ball_y} >= rack_r_bot));

  assign vel_sum    = {1'b0, velocity} + {1'b0, VEL_STEP};
  assign vel_bumped = (vel_sum > {1'b0, VEL_MAX}) ? VEL_MAX : vel_sum[15:0];

  assign state = cur_state;

  // Registers every game output so downstream logic sees clean, glitch-free values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state   <= IDLE;
      frame_cnt   <= 8'd0;
      velocity    <= VEL_INIT;
      score_L     <= 4'd0;
      score_R     <= 4'd0;
      winner      <= 1'b0;
      ball_serve  <= 1'b0;
      ball_enable <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      frame_cnt   <= cnt_n;
      velocity    <= vel_n;
      score_L     <= score_l_n;
      score_R     <= score_r_n;
      winner      <= winner_n;
      ball_serve  <= serve_n;
      ball_enable <= enable_n;
      game_over   <= over_n;
    end
  end

  // Next-state and next-output decisions; start is checked every cycle, the rest only on frame strobes
  always_comb begin
    nxt_state = cur_state;
    cnt_n     = frame_cnt;
    vel_n     = velocity;
    score_l_n = score_L;
    score_r_n = score_R;
    winner_n  = winner;
    serve_n   = 1'b0;

    case (cur_state)
      IDLE, GAME_OVER: begin
        if (start_btn) begin
          score_l_n = 4'd0;
          score_r_n = 4'd0;
          vel_n     = VEL_INIT;
          serve_n   = 1'b1;
          cnt_n     = 8'd0;
          nxt_state = SERVE;
        end
      end

      SERVE: begin
        if (frame_start_strobe) begin
          if (frame_cnt == SERVE_LAST) begin
            cnt_n     = 8'd0;
            nxt_state = PLAY;
          end else begin
            cnt_n = frame_cnt + 8'd1;
          end
        end
      end

      PLAY: begin
        if (frame_start_strobe) begin
          if (miss_l) begin
            score_r_n = score_R + 4'd1;
            cnt_n     = 8'd0;
            if (score_r_n == WIN) begin
              winner_n  = 1'b1;
              nxt_state = GAME_OVER;
            end else begin
              nxt_state = POINT;
            end
          end else if (miss_r) begin
            score_l_n = score_L + 4'd1;
            cnt_n     = 8'd0;
            if (score_l_n == WIN) begin
              winner_n  = 1'b0;
              nxt_state = GAME_OVER;
            end else begin
              nxt_state = POINT;
            end
          end else if (ball_bounce) begin
            vel_n = vel_bumped;
          end
        end
      end

      POINT: begin
        if (frame_start_strobe) begin
          if (frame_cnt == POINT_LAST) begin
            vel_n     = VEL_INIT;
            serve_n   = 1'b1;
            cnt_n     = 8'd0;
            nxt_state = SERVE;
          end else begin
            cnt_n = frame_cnt + 8'd1;
          end
        end
      end

      default: nxt_state = IDLE;
    endcase

    enable_n = (nxt_state == PLAY);
    over_n   = (nxt_state == GAME_OVER);
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: expectations are queued as stimulus is
// applied and drained against the DUT right after the clock edge.
module tb_pong_game_ctrl;

  localparam int S_STATE = 0;
  localparam int S_EN    = 1;
  localparam int S_SERVE = 2;
  localparam int S_VEL   = 3;
  localparam int S_SL    = 4;
  localparam int S_SR    = 5;
  localparam int S_OVER  = 6;
  localparam int S_WIN   = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start_strobe = 1'b0;
  logic        start_btn = 1'b0;
  logic        ball_bounce = 1'b0;
  logic [11:0] ball_x = 12'd640;
  logic [11:0] ball_y = 12'd300;
  logic [11:0] rack_y_L = 12'd280;
  logic [11:0] rack_y_R = 12'd280;
  logic        ball_enable;
  logic        ball_serve;
  logic [15:0] velocity;
  logic [3:0]  score_L;
  logic [3:0]  score_R;
  logic        game_over;
  logic        winner;
  logic [2:0]  state;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] value;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  pong_game_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .frame_start_strobe (frame_start_strobe),
    .start_btn          (start_btn),
    .ball_x             (ball_x),
    .ball_y             (ball_y),
    .rack_y_L           (rack_y_L),
    .rack_y_R           (rack_y_R),
    .ball_bounce        (ball_bounce),
    .ball_enable        (ball_enable),
    .ball_serve         (ball_serve),
    .velocity           (velocity),
    .score_L            (score_L),
    .score_R            (score_R),
    .game_over          (game_over),
    .winner             (winner),
    .state              (state)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] observe(int sel);
    case (sel)
      S_STATE: return {13'd0, state};
      S_EN:    return {15'd0, ball_enable};
      S_SERVE: return {15'd0, ball_serve};
      S_VEL:   return velocity;
      S_SL:    return {12'd0, score_L};
      S_SR:    return {12'd0, score_R};
      S_OVER:  return {15'd0, game_over};
      S_WIN:   return {15'd0, winner};
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [15:0] value);
    exp_t e;
    e.tag   = tag;
    e.sel   = sel;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [15:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = observe(e.sel);
      checks++;
      assert (got === e.value) else begin
        failures++;
        $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, got, e.value);
      end
    end
  endtask

  task automatic applyStimulus(input logic strobe, input logic start, input logic bounce);
    frame_start_strobe = strobe;
    start_btn          = start;
    ball_bounce        = bounce;
    @(posedge clk);
    #1;
    frame_start_strobe = 1'b0;
    start_btn          = 1'b0;
    ball_bounce        = 1'b0;
  endtask

  task automatic set_pos(input int bx, input int by, input int rl, input int rr);
    ball_x   = 12'(bx);
    ball_y   = 12'(by);
    rack_y_L = 12'(rl);
    rack_y_R = 12'(rr);
  endtask

  task automatic run_strobes(input int n, input logic bounce);
    repeat (n) applyStimulus(1'b1, 1'b0, bounce);
  endtask

  // From POINT: finish the pause, then the serve hold, landing in PLAY
  task automatic back_to_play(input string tag);
    set_pos(640, 300, 280, 280);
    run_strobes(30, 1'b0);
    run_strobes(60, 1'b0);
    expect_out(tag, S_STATE, 16'd2);
    expect_out(tag, S_EN, 16'd1);
    checkOutput();
  endtask

  initial begin
    int          by_r[4];
    int          rr_r[4];
    logic [15:0] exp_vel;

    by_r = '{154, 284, 10, 10};
    rr_r = '{90, 300, 300, 300};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    expect_out("rst_state", S_STATE, 16'd0);
    expect_out("rst_en", S_EN, 16'd0);
    expect_out("rst_serve", S_SERVE, 16'd0);
    expect_out("rst_vel", S_VEL, 16'h0100);
    expect_out("rst_sl", S_SL, 16'd0);
    expect_out("rst_sr", S_SR, 16'd0);
    expect_out("rst_over", S_OVER, 16'd0);
    expect_out("rst_win", S_WIN, 16'd0);
    checkOutput();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    expect_out("idle_hold", S_STATE, 16'd0);
    checkOutput();

    // Start together with a strobe: start taken, strobe not counted
    expect_out("start_state", S_STATE, 16'd1);
    expect_out("start_serve", S_SERVE, 16'd1);
    expect_out("start_en", S_EN, 16'd0);
    expect_out("start_sl", S_SL, 16'd0);
    expect_out("start_sr", S_SR, 16'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput();
    expect_out("serve_pulse_end", S_SERVE, 16'd0);
    expect_out("serve_ign_start", S_STATE, 16'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput();
    run_strobes(59, 1'b0);
    expect_out("serve_59", S_STATE, 16'd1);
    expect_out("serve_59_en", S_EN, 16'd0);
    checkOutput();
    expect_out("play_state", S_STATE, 16'd2);
    expect_out("play_en", S_EN, 16'd1);
    expect_out("play_vel", S_VEL, 16'h0100);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();

    // Two bounces, then a left miss with bounce asserted
    run_strobes(2, 1'b1);
    expect_out("bounce2_vel", S_VEL, 16'h0120);
    checkOutput();
    set_pos(8, 100, 200, 280);
    expect_out("missl_sr", S_SR, 16'd1);
    expect_out("missl_sl", S_SL, 16'd0);
    expect_out("missl_en", S_EN, 16'd0);
    expect_out("missl_state", S_STATE, 16'd3);
    expect_out("missl_vel", S_VEL, 16'h0120);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput();
    set_pos(640, 300, 280, 280);
    run_strobes(29, 1'b0);
    expect_out("point_29", S_STATE, 16'd3);
    expect_out("point_29_serve", S_SERVE, 16'd0);
    checkOutput();
    expect_out("reserve_state", S_STATE, 16'd1);
    expect_out("reserve_serve", S_SERVE, 16'd1);
    expect_out("reserve_vel", S_VEL, 16'h0100);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    expect_out("reserve_pulse_end", S_SERVE, 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput();
    run_strobes(60, 1'b0);
    expect_out("play2_state", S_STATE, 16'd2);
    checkOutput();

    // Covered and near-edge positions: no score
    set_pos(1256, 100, 280, 90);
    expect_out("cov_r_state", S_STATE, 16'd2);
    expect_out("cov_r_sl", S_SL, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    set_pos(1256, 285, 280, 300);
    expect_out("cov_r_top", S_SL, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    set_pos(8, 343, 280, 280);
    expect_out("cov_l_bot", S_SR, 16'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    set_pos(1255, 10, 280, 300);
    expect_out("edge_r_inside", S_STATE, 16'd2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    set_pos(9, 10, 300, 280);
    expect_out("edge_l_inside", S_STATE, 16'd2);
    expect_out("edge_l_sr", S_SR, 16'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    set_pos(640, 300, 280, 280);

    // Velocity ramp with saturation
    exp_vel = 16'h0100;
    for (int i = 1; i <= 50; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      exp_vel = (exp_vel + 16'h0010 > 16'h0400) ? 16'h0400 : exp_vel + 16'h0010;
      expect_out($sformatf("ramp_%0d", i), S_VEL, exp_vel);
      checkOutput();
    end
    expect_out("ramp_state", S_STATE, 16'd2);
    checkOutput();

    // Four right misses bring left to 4, then the winning point
    for (int k = 0; k < 4; k++) begin
      set_pos(1256, by_r[k], 280, rr_r[k]);
      expect_out($sformatf("missr_%0d_sl", k + 1), S_SL, 16'(k + 1));
      expect_out($sformatf("missr_%0d_state", k + 1), S_STATE, 16'd3);
      expect_out($sformatf("missr_%0d_vel", k + 1), S_VEL, (k == 0) ? 16'h0400 : 16'h0100);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput();
      back_to_play($sformatf("replay_%0d", k + 1));
    end
    set_pos(1256, 10, 280, 300);
    expect_out("winl_sl", S_SL, 16'd5);
    expect_out("winl_sr", S_SR, 16'd1);
    expect_out("winl_state", S_STATE, 16'd4);
    expect_out("winl_over", S_OVER, 16'd1);
    expect_out("winl_winner", S_WIN, 16'd0);
    expect_out("winl_en", S_EN, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    set_pos(8, 10, 300, 280);
    expect_out("frozen_sr", S_SR, 16'd1);
    expect_out("frozen_sl", S_SL, 16'd5);
    expect_out("frozen_state", S_STATE, 16'd4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    expect_out("restart_state", S_STATE, 16'd1);
    expect_out("restart_sl", S_SL, 16'd0);
    expect_out("restart_sr", S_SR, 16'd0);
    expect_out("restart_serve", S_SERVE, 16'd1);
    expect_out("restart_over", S_OVER, 16'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput();
    set_pos(640, 300, 280, 280);
    run_strobes(60, 1'b0);

    // Right player wins the second match
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) set_pos(8, 344, 280, 280);
      else set_pos(8, 10, 300, 280);
      expect_out($sformatf("missl_%0d_sr", k), S_SR, 16'(k));
      expect_out($sformatf("missl_%0d_state", k), S_STATE, (k == 5) ? 16'd4 : 16'd3);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput();
      if (k < 5) back_to_play($sformatf("replay_r_%0d", k));
    end
    expect_out("winr_winner", S_WIN, 16'd1);
    expect_out("winr_over", S_OVER, 16'd1);
    checkOutput();
    set_pos(640, 300, 280, 280);
    applyStimulus(1'b0, 1'b1, 1'b0);
    run_strobes(60, 1'b0);
    run_strobes(1, 1'b1);
    expect_out("pre_rst_vel", S_VEL, 16'h0110);
    expect_out("pre_rst_state", S_STATE, 16'd2);
    checkOutput();

    // Asynchronous reset between clock edges
    #3;
    reset = 1'b1;
    #1;
    expect_out("arst_state", S_STATE, 16'd0);
    expect_out("arst_en", S_EN, 16'd0);
    expect_out("arst_vel", S_VEL, 16'h0100);
    expect_out("arst_win", S_WIN, 16'd0);
    expect_out("arst_over", S_OVER, 16'd0);
    checkOutput();
    #2;
    reset = 1'b0;
    expect_out("post_rst_state", S_STATE, 16'd0);
    expect_out("post_rst_serve", S_SERVE, 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-flow controller that sequences the bouncing-ball/racket datapath into a two-player pong match. It gates the ball datapath `enable`, re-serves the ball and ramps its `velocity` on every bounce. Once per frame it checks for misses by comparing ball and racket positions, keeps both scores and declares a winner. It sits between the player inputs/frame timing and the ball datapath, and feeds the score and state overlay renderer.

Parameters:
LEFT_X, 8, pixel x at or below which the left racket must cover the ball
RIGHT_X, 1256, pixel x at or above which the right racket must cover the ball
RACK_H, 64, racket height in pixels
BALL_H, 16, ball height in pixels
SERVE_FRAMES, 60, frames the ball is held before release
POINT_FRAMES, 30, frames of pause after a point
WIN_SCORE, 5, score that ends the match (1..15)
VEL_INIT, 16'h0100, velocity at each serve
VEL_STEP, 16'h0010, velocity increment per bounce
VEL_MAX, 16'h0400, velocity ceiling

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_start_strobe  in  1  one-cycle pulse per frame; all game decisions are taken on it
start_btn  in  1  level, already debounced; starts or restarts a match
ball_x  in  12  ball pixel x (ball 0 from datapath)
ball_y  in  12  ball pixel y
rack_y_L  in  12  left racket top pixel y
rack_y_R  in  12  right racket top pixel y
ball_bounce  in  1  datapath bounce flag, valid on frame_start_strobe
ball_enable  out  1  drives datapath enable
ball_serve  out  1  one-cycle pulse; re-initialises ball position and direction
velocity  out  16  drives datapath velocity
score_L  out  4  left player score
score_R  out  4  right player score
game_over  out  1  high in GAME_OVER
winner  out  1  0 = left, 1 = right; valid while game_over
state  out  3  encoded FSM state, for overlay and debug

Behaviour:
- Reset is asynchronous and active-high and forces:
  - state = IDLE
  - ball_enable = 0, ball_serve = 0
  - velocity = VEL_INIT
  - score_L = score_R = 0
  - game_over = 0, winner = 0
  - frame counter = 0
- All outputs are registered. A decision taken on a strobe cycle is visible on the next clk edge. Inputs are sampled only on cycles where frame_start_strobe = 1, except start_btn, which is sampled every cycle.
- FSM states, encoding 0..4: IDLE, SERVE, PLAY, POINT, GAME_OVER.
  - IDLE: start_btn = 1 -> clear scores, velocity = VEL_INIT, pulse ball_serve, frame counter = 0, go to SERVE.
  - SERVE: ball_enable = 0. Each strobe increments the frame counter. On the strobe where the counter equals SERVE_FRAMES-1, go to PLAY and set ball_enable = 1.
  - PLAY: ball_enable = 1. On each strobe:
    - Miss left: ball_x <= LEFT_X and (ball_y + BALL_H <= rack_y_L, or ball_y >= rack_y_L + RACK_H). Right player scores.
    - Miss right: ball_x >= RIGHT_X with the same test against rack_y_R. Left player scores.
    - Sums are computed at 13 bits with no wrap.
    - If both misses hold on the same strobe, the left miss has priority.
    - On a miss: increment the scorer's score, set ball_enable = 0, clear the counter.
      - If the new score equals WIN_SCORE, go to GAME_OVER and set winner to the scorer.
      - Otherwise go to POINT.
    - With no miss and ball_bounce = 1: velocity = min(velocity + VEL_STEP, VEL_MAX), computed at 17 bits then saturated.
    - A miss takes precedence over a bounce on the same strobe; velocity is unchanged.
  - POINT: ball_enable = 0. Count strobes. On the strobe where the counter equals POINT_FRAMES-1: velocity = VEL_INIT, pulse ball_serve, clear the counter, go to SERVE.
  - GAME_OVER: game_over = 1, ball_enable = 0, scores frozen. start_btn = 1 -> same action as IDLE start.
- start_btn is ignored in SERVE, PLAY and POINT.
- ball_serve is high for exactly one clk cycle per serve.
- Scores never exceed WIN_SCORE.
- The frame counter is 8 bits wide. SERVE_FRAMES and POINT_FRAMES must lie in 1..256.
- Reset asserted mid-match returns to IDLE immediately and asynchronously. There is no pending ball_serve after reset release.
- A strobe and start_btn in the same cycle while in IDLE: the start is taken. The strobe is not counted toward SERVE.

Test Plan:
1. Reset, then start_btn = 1 for 1 cycle -> ball_serve pulse of 1 cycle, state = SERVE, scores 0/0. After 60 strobes -> state = PLAY, ball_enable = 1, velocity = 16'h0100.
2. PLAY, strobe with ball_x = 8, ball_y = 100, rack_y_L = 200 -> score_R = 1, ball_enable = 0, state = POINT. After 30 strobes -> ball_serve pulse, state = SERVE, velocity = 16'h0100.
3. PLAY, ball_x = 1256, ball_y = 100, rack_y_R = 90 (ball covered) -> no score change, state stays PLAY.
4. PLAY, 50 strobes with ball_bounce = 1 and no miss -> velocity reaches 16'h0400 after 48 bounces and holds at 16'h0400.
5. score_L = 4, strobe with a right-side miss -> score_L = 5, state = GAME_OVER, game_over = 1, winner = 0. Then start_btn -> scores 0/0, state = SERVE.
6. Assert reset asynchronously in PLAY between clock edges -> outputs at reset values immediately. ball_enable = 0 and state = IDLE before the next clk edge.
